// File: rtl/des_pkg.sv
// Shared DES key-schedule definitions: widths, shift schedule, PC-2 selection
// table and the per-half rotate helper used by the schedule generator.
package des_pkg;

    localparam int SUBKEY_W = 48;
    localparam int HALF_W   = 28;
    localparam int CD_W     = 2 * HALF_W;
    localparam int ROUNDS   = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Entry r-1 holds the shift for round r: 0 means rotate by 1, 1 means by 2.
    localparam logic [0:ROUNDS-1] SHIFT_TWO = 16'b0011_1111_0111_1110;

    // PC-2: subkey bit i+1 is taken from C||D bit PC2_TABLE[i] (both 1-based).
    localparam int PC2_TABLE [0:SUBKEY_W-1] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Rotate one 28-bit half by one or two places; bit 1 is the MSB.
    function automatic logic [1:HALF_W] rot_half(
        input logic [1:HALF_W] half,
        input logic            left,
        input logic            two
    );
        logic [1:HALF_W] result;
        case ({left, two})
            2'b10:   result = {half[2:HALF_W], half[1]};
            2'b11:   result = {half[3:HALF_W], half[1:2]};
            2'b00:   result = {half[HALF_W], half[1:HALF_W-1]};
            default: result = {half[HALF_W-1:HALF_W], half[1:HALF_W-2]};
        endcase
        return result;
    endfunction

endpackage

// File: rtl/des_pc1.sv
// DES Permuted Choice 1: selects the 56 key bits (parity bits dropped) into C0||D0.
module des_pc1 (
    input  logic [1:64] key,
    output logic [1:56] cd
);

    localparam int PC1_TABLE [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    for (genvar g = 0; g < 56; g++) begin : g_sel
        assign cd[g+1] = key[PC1_TABLE[g]];
    end

    // The byte parity bits play no part in the permutation.
    logic unused_parity_bits;
    assign unused_parity_bits = ^{key[8], key[16], key[24], key[32],
                                  key[40], key[48], key[56], key[64]};

endmodule

// File: rtl/des_pc2.sv
// DES Permuted Choice 2: compresses the 56-bit C||D register into a 48-bit subkey.
module des_pc2
    import des_pkg::*;
(
    input  logic [1:CD_W]     cd,
    output logic [1:SUBKEY_W] subkey
);

    for (genvar g = 0; g < SUBKEY_W; g++) begin : g_sel
        assign subkey[g+1] = cd[PC2_TABLE[g]];
    end

    // C||D bits 9, 18, 22, 25, 35, 38, 43 and 54 are never selected by PC-2.
    logic unused_cd_bits;
    assign unused_cd_bits = ^{cd[9], cd[18], cd[22], cd[25],
                              cd[35], cd[38], cd[43], cd[54]};

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: takes a key over valid/ready and streams the 16
// PC-2 subkeys in encrypt or decrypt order under consumer backpressure.
module des_key_schedule
    import des_pkg::*;
#(
    parameter int CHECK_PARITY = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_valid,
    output logic              key_ready,
    input  logic [1:64]       key,
    input  logic              decrypt,
    input  logic              abort,
    output logic              sk_valid,
    input  logic              sk_ready,
    output logic [1:SUBKEY_W] subkey,
    output logic [3:0]        sk_round,
    output logic              sk_last,
    output logic              key_parity_err
);

    state_t            state;
    state_t            state_next;
    logic [1:CD_W]     pc1_cd;
    logic [1:HALF_W]   c_reg;
    logic [1:HALF_W]   d_reg;
    logic [3:0]        count;
    logic              dir;
    logic              accept;
    logic              advance;
    logic              last;
    logic              shift_two;
    logic [0:7]        byte_even;
    logic              parity_calc;

    des_pc1 u_pc1 (
        .key (key),
        .cd  (pc1_cd)
    );

    // Subkey is driven from the C/D registers only, never from the inputs.
    des_pc2 u_pc2 (
        .cd     ({c_reg, d_reg}),
        .subkey (subkey)
    );

    assign last    = (count == 4'd15);
    assign accept  = key_valid && key_ready;
    assign advance = (state == RUN) && sk_ready && !abort;

    // Encrypt K(r)->K(r+1) uses S[r+1]; decrypt K(r)->K(r-1) uses S[r].
    assign shift_two = dir ? SHIFT_TWO[4'd15 - count] : SHIFT_TWO[count + 4'd1];

    for (genvar g = 0; g < 8; g++) begin : g_parity
        assign byte_even[g] = ~^key[8*g+1 +: 8];
    end
    assign parity_calc = |byte_even;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: each always_comb assigns a default first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (sk_ready && last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        key_ready = 1'b0;
        sk_valid  = 1'b0;
        sk_round  = 4'd0;
        sk_last   = 1'b0;
        case (state)
            IDLE: begin
                key_ready = 1'b1;
            end
            RUN: begin
                sk_valid = 1'b1;
                sk_round = dir ? (4'd15 - count) : count;
                sk_last  = last;
            end
            default: ;
        endcase
    end

    // Decrypt loads C0D0 unrotated: the rotations total 28, so C16D16 == C0D0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_reg <= '0;
            d_reg <= '0;
            count <= 4'd0;
            dir   <= 1'b0;
        end else if (accept) begin
            dir   <= decrypt;
            count <= 4'd0;
            if (decrypt) begin
                c_reg <= pc1_cd[1:HALF_W];
                d_reg <= pc1_cd[HALF_W+1:CD_W];
            end else begin
                c_reg <= rot_half(pc1_cd[1:HALF_W], 1'b1, 1'b0);
                d_reg <= rot_half(pc1_cd[HALF_W+1:CD_W], 1'b1, 1'b0);
            end
        end else if (advance && !last) begin
            count <= count + 4'd1;
            c_reg <= rot_half(c_reg, !dir, shift_two);
            d_reg <= rot_half(d_reg, !dir, shift_two);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_parity_err <= 1'b0;
        end else if (accept) begin
            key_parity_err <= (CHECK_PARITY != 0) && parity_calc;
        end
    end

endmodule
